// File: rtl/mem_arbiter.sv
// Shared 16-bit SRAM sequencer: serialises the EX/MEM data access and the IF fetch
// into back-to-back SRAM transactions, stalling the pipeline until both complete.
module mem_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  memReadIn,
  input  logic [1:0]  memWriteIn,
  input  logic [15:0] ALUResultIn,
  input  logic [15:0] dataIn,
  input  logic        ifReq,
  input  logic [15:0] ifAddr,
  output logic [15:0] memDataOut,
  output logic [15:0] instrOut,
  output logic        stall,
  output logic [15:0] ramAddr,
  output logic [15:0] ramDataOut,
  input  logic [15:0] ramDataIn,
  output logic        ramDataOE,
  output logic        ramCE_N,
  output logic        ramOE_N,
  output logic        ramWE_N
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_RD  = 3'd1,
    D_WR  = 3'd2,
    FETCH = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [3:0] PH_LAST = 4'(WAIT_CYCLES);
  localparam logic [3:0] PH_HOLD = 4'(WAIT_CYCLES + 1);

  state_t     state;
  logic [3:0] ph;
  logic       d_rd;
  logic       d_wr;

  // A load takes priority over a store presented in the same cycle.
  always_comb begin
    d_rd = (memReadIn == 2'b01);
    d_wr = (memWriteIn == 2'b01) & ~d_rd;
  end

  // Pipeline hold: asserted while any transaction is pending or in flight.
  always_comb begin
    stall = 1'b0;
    if (!RST) begin
      stall = 1'b0;
    end else begin
      case (state)
        IDLE:              stall = d_rd | d_wr | ifReq;
        D_RD, D_WR, FETCH: stall = 1'b1;
        DONE:              stall = 1'b0;
        default:           stall = 1'b0;
      endcase
    end
  end

  // Sequencer FSM; strobes are set for the state/phase being entered so every pin is registered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      ph         <= 4'd0;
      ramAddr    <= 16'h0000;
      ramDataOut <= 16'h0000;
      memDataOut <= 16'h0000;
      instrOut   <= 16'h0000;
      ramDataOE  <= 1'b0;
      ramCE_N    <= 1'b1;
      ramOE_N    <= 1'b1;
      ramWE_N    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ph <= 4'd0;
          if (d_rd) begin
            state   <= D_RD;
            ramAddr <= ALUResultIn;
            ramCE_N <= 1'b0;
            ramOE_N <= 1'b0;
          end else if (d_wr) begin
            state      <= D_WR;
            ramAddr    <= ALUResultIn;
            ramDataOut <= dataIn;
            ramCE_N    <= 1'b0;
            ramDataOE  <= 1'b1;
          end else if (ifReq) begin
            state   <= FETCH;
            ramAddr <= ifAddr;
            ramCE_N <= 1'b0;
            ramOE_N <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        D_RD: begin
          if (ph == PH_LAST) begin
            memDataOut <= ramDataIn;
            ph         <= 4'd0;
            if (ifReq) begin
              state   <= FETCH;
              ramAddr <= ifAddr;
            end else begin
              state   <= DONE;
              ramCE_N <= 1'b1;
              ramOE_N <= 1'b1;
            end
          end else begin
            ph <= ph + 4'd1;
          end
        end

        D_WR: begin
          // WE is released one phase before the exit so it never moves with the address.
          if (ph == PH_HOLD) begin
            ph        <= 4'd0;
            ramDataOE <= 1'b0;
            ramWE_N   <= 1'b1;
            if (ifReq) begin
              state   <= FETCH;
              ramAddr <= ifAddr;
              ramOE_N <= 1'b0;
            end else begin
              state   <= DONE;
              ramCE_N <= 1'b1;
            end
          end else begin
            ph <= ph + 4'd1;
            if (ph == 4'd0) begin
              ramWE_N <= 1'b0;
            end else if (ph == PH_LAST) begin
              ramWE_N <= 1'b1;
            end else begin
              ramWE_N <= ramWE_N;
            end
          end
        end

        FETCH: begin
          if (ph == PH_LAST) begin
            instrOut <= ramDataIn;
            ph       <= 4'd0;
            state    <= DONE;
            ramCE_N  <= 1'b1;
            ramOE_N  <= 1'b1;
          end else begin
            ph <= ph + 4'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          ph    <= 4'd0;
        end

        default: begin
          state     <= IDLE;
          ph        <= 4'd0;
          ramDataOE <= 1'b0;
          ramCE_N   <= 1'b1;
          ramOE_N   <= 1'b1;
          ramWE_N   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven transactions with a scoreboard queue
// on a W=1 and a W=3 instance, plus a hand-written reset-during-store sequence.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  mem_read, mem_write;
  logic [15:0] alu, data_in, if_addr;
  logic        if_req;

  logic [15:0] mem_data1, instr1, ram_addr1, ram_dout1, ram_din1;
  logic        stall1, doe1, ce1, oe1, we1;
  logic [15:0] mem_data3, instr3, ram_addr3, ram_dout3, ram_din3;
  logic        stall3, doe3, ce3, oe3, we3;

  logic        sel_w3;
  logic [15:0] m_addr, m_dout, m_mem, m_instr;
  logic        m_stall, m_doe, m_oe, m_we;

  int checks = 0;
  int passes = 0;

  always #5 CLK = ~CLK;

  function automatic logic [15:0] sram_word(input logic [15:0] a);
    case (a)
      16'h0040: return 16'h1234;
      16'h0041: return 16'h5678;
      16'h8000: return 16'hBEEF;
      default:  return ~a;
    endcase
  endfunction

  assign ram_din1 = sram_word(ram_addr1);
  assign ram_din3 = sram_word(ram_addr3);

  assign m_addr  = sel_w3 ? ram_addr3 : ram_addr1;
  assign m_dout  = sel_w3 ? ram_dout3 : ram_dout1;
  assign m_mem   = sel_w3 ? mem_data3 : mem_data1;
  assign m_instr = sel_w3 ? instr3    : instr1;
  assign m_stall = sel_w3 ? stall3    : stall1;
  assign m_doe   = sel_w3 ? doe3      : doe1;
  assign m_oe    = sel_w3 ? oe3       : oe1;
  assign m_we    = sel_w3 ? we3       : we1;

  mem_arbiter #(.WAIT_CYCLES(1)) dut1 (
    .CLK(CLK), .RST(RST), .memReadIn(mem_read), .memWriteIn(mem_write),
    .ALUResultIn(alu), .dataIn(data_in), .ifReq(if_req), .ifAddr(if_addr),
    .memDataOut(mem_data1), .instrOut(instr1), .stall(stall1),
    .ramAddr(ram_addr1), .ramDataOut(ram_dout1), .ramDataIn(ram_din1),
    .ramDataOE(doe1), .ramCE_N(ce1), .ramOE_N(oe1), .ramWE_N(we1)
  );

  mem_arbiter #(.WAIT_CYCLES(3)) dut3 (
    .CLK(CLK), .RST(RST), .memReadIn(mem_read), .memWriteIn(mem_write),
    .ALUResultIn(alu), .dataIn(data_in), .ifReq(if_req), .ifAddr(if_addr),
    .memDataOut(mem_data3), .instrOut(instr3), .stall(stall3),
    .ramAddr(ram_addr3), .ramDataOut(ram_dout3), .ramDataIn(ram_din3),
    .ramDataOE(doe3), .ramCE_N(ce3), .ramOE_N(oe3), .ramWE_N(we3)
  );

  typedef struct {
    logic        w3;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        ifq;
    logic [15:0] alu;
    logic [15:0] data;
    logic [15:0] ifa;
    int          cycles;
    logic [15:0] mem;
    logic [15:0] instr;
    logic [15:0] addr_first;
    logic [15:0] addr_last;
    int          we_low;
    int          doe_cycles;
  } vec_t;

  typedef struct {
    int          cycles;
    logic [15:0] mem;
    logic [15:0] instr;
    logic [15:0] addr_first;
    logic [15:0] addr_last;
    int          we_low;
    int          doe_cycles;
  } exp_t;

  vec_t vecs[9];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    mem_read  = 2'b00;
    mem_write = 2'b00;
    if_req    = 1'b0;
    alu       = 16'h0000;
    data_in   = 16'h0000;
    if_addr   = 16'h0000;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int cyc, we_low, doe_c, conflicts, bad_data, wechg;
    logic done;
    logic [15:0] first, last, prev_addr;
    logic prev_we;
    cyc = 0; we_low = 0; doe_c = 0; conflicts = 0; bad_data = 0; wechg = 0;
    done = 1'b0; first = 16'h0000; last = 16'h0000; prev_addr = 16'h0000; prev_we = 1'b1;

    @(negedge CLK);
    RST = 1'b0;
    idle_inputs();
    sel_w3 = v.w3;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    mem_read  = v.rd;
    mem_write = v.wr;
    if_req    = v.ifq;
    alu       = v.alu;
    data_in   = v.data;
    if_addr   = v.ifa;
    e.cycles = v.cycles; e.mem = v.mem; e.instr = v.instr;
    e.addr_first = v.addr_first; e.addr_last = v.addr_last;
    e.we_low = v.we_low; e.doe_cycles = v.doe_cycles;
    sb_q.push_back(e);

    while (!done && cyc < 60) begin
      if (cyc > 0) @(negedge CLK);
      #1;
      cyc++;
      if (!m_oe && !m_we) conflicts++;
      if (!m_we) we_low++;
      if (m_doe) begin
        doe_c++;
        if (m_dout !== v.data) bad_data++;
      end
      if (cyc == 2) first = m_addr;
      if (cyc > 1 && m_addr !== prev_addr && m_we !== prev_we) wechg++;
      prev_addr = m_addr;
      prev_we   = m_we;
      if (!m_stall) done = 1'b1;
      else last = m_addr;
    end
    idle_inputs();

    e = sb_q.pop_front();
    check($sformatf("v%0d_done_reached", idx), 32'(done), 32'd1);
    check($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(e.cycles));
    check($sformatf("v%0d_memDataOut", idx), 32'(m_mem), 32'(e.mem));
    check($sformatf("v%0d_instrOut", idx), 32'(m_instr), 32'(e.instr));
    check($sformatf("v%0d_addr_first", idx), 32'(first), 32'(e.addr_first));
    check($sformatf("v%0d_addr_last", idx), 32'(last), 32'(e.addr_last));
    check($sformatf("v%0d_we_low_cycles", idx), 32'(we_low), 32'(e.we_low));
    check($sformatf("v%0d_dataoe_cycles", idx), 32'(doe_c), 32'(e.doe_cycles));
    check($sformatf("v%0d_oe_we_overlap", idx), 32'(conflicts), 32'd0);
    check($sformatf("v%0d_store_data_bad", idx), 32'(bad_data), 32'd0);
    check($sformatf("v%0d_we_addr_same_edge", idx), 32'(wechg), 32'd0);
  endtask

  initial begin
    // w3 rd wr ifq alu data ifa | cycles mem instr first last we_low doe
    vecs[0] = '{1'b1, 2'b10, 2'b11, 1'b1, 16'h8000, 16'h0000, 16'h0040,
                6, 16'h0000, 16'h1234, 16'h0040, 16'h0040, 0, 0};
    vecs[1] = '{1'b1, 2'b00, 2'b01, 1'b1, 16'h9000, 16'hA5A5, 16'h0041,
                11, 16'h0000, 16'h5678, 16'h9000, 16'h0041, 3, 5};
    vecs[2] = '{1'b0, 2'b00, 2'b00, 1'b1, 16'h0000, 16'h0000, 16'h0040,
                4, 16'h0000, 16'h1234, 16'h0040, 16'h0040, 0, 0};
    vecs[3] = '{1'b0, 2'b01, 2'b00, 1'b1, 16'h8000, 16'h0000, 16'h0041,
                6, 16'hBEEF, 16'h5678, 16'h8000, 16'h0041, 0, 0};
    vecs[4] = '{1'b0, 2'b00, 2'b01, 1'b0, 16'h9000, 16'hA5A5, 16'h0040,
                5, 16'h0000, 16'h0000, 16'h9000, 16'h9000, 1, 3};
    vecs[5] = '{1'b0, 2'b10, 2'b11, 1'b1, 16'h8000, 16'h1111, 16'h0040,
                4, 16'h0000, 16'h1234, 16'h0040, 16'h0040, 0, 0};
    vecs[6] = '{1'b0, 2'b01, 2'b01, 1'b1, 16'h8000, 16'h1111, 16'h0041,
                6, 16'hBEEF, 16'h5678, 16'h8000, 16'h0041, 0, 0};
    vecs[7] = '{1'b0, 2'b00, 2'b01, 1'b1, 16'h9000, 16'hA5A5, 16'h0040,
                7, 16'h0000, 16'h1234, 16'h9000, 16'h0040, 1, 3};
    vecs[8] = '{1'b0, 2'b01, 2'b00, 1'b0, 16'h8000, 16'h0000, 16'h0000,
                4, 16'hBEEF, 16'h0000, 16'h8000, 16'h8000, 0, 0};

    sel_w3 = 1'b0;
    RST = 1'b0;
    idle_inputs();
    if_req = 1'b1;
    #12;
    check("reset_stall_with_req", 32'(stall1), 32'd0);
    check("reset_we", 32'(we1), 32'd1);
    check("reset_ce", 32'(ce1), 32'd1);
    check("reset_addr", 32'(ram_addr1), 32'd0);
    if_req = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset during the WE-low phase of a store on the W=1 instance.
    sel_w3 = 1'b0;
    @(negedge CLK);
    mem_write = 2'b01;
    alu       = 16'h9000;
    data_in   = 16'hA5A5;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("midstore_we_low_before_reset", 32'(we1), 32'd0);
    check("midstore_mem_before_reset", 32'(mem_data1), 32'hBEEF);
    #2;
    RST = 1'b0;
    if_req = 1'b1;
    #1;
    check("midstore_rst_we", 32'(we1), 32'd1);
    check("midstore_rst_ce", 32'(ce1), 32'd1);
    check("midstore_rst_oe", 32'(oe1), 32'd1);
    check("midstore_rst_dataoe", 32'(doe1), 32'd0);
    check("midstore_rst_stall", 32'(stall1), 32'd0);
    check("midstore_rst_addr", 32'(ram_addr1), 32'd0);
    check("midstore_rst_dout", 32'(ram_dout1), 32'd0);
    check("midstore_rst_mem", 32'(mem_data1), 32'd0);
    check("midstore_rst_instr", 32'(instr1), 32'd0);
    if_req = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("restart_idle_stall", 32'(stall1), 32'd1);
    check("restart_idle_we", 32'(we1), 32'd1);
    @(negedge CLK);
    #1;
    check("restart_ph0_ce", 32'(ce1), 32'd0);
    check("restart_ph0_we", 32'(we1), 32'd1);
    check("restart_ph0_dataoe", 32'(doe1), 32'd1);
    check("restart_ph0_addr", 32'(ram_addr1), 32'h9000);
    check("restart_ph0_dout", 32'(ram_dout1), 32'hA5A5);
    @(negedge CLK);
    #1;
    check("restart_ph1_we", 32'(we1), 32'd0);
    @(negedge CLK);
    #1;
    check("restart_ph2_we", 32'(we1), 32'd1);
    check("restart_ph2_stall", 32'(stall1), 32'd1);
    @(negedge CLK);
    #1;
    check("restart_done_stall", 32'(stall1), 32'd0);
    check("restart_done_ce", 32'(ce1), 32'd1);
    idle_inputs();
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequencer for the single shared 16-bit SRAM, which serves both instruction fetch and the data access requested by the EX/MEM pipeline register. Each pipeline advance is split into serialized SRAM transactions: data access first, then fetch. The block holds the pipeline with `stall` until both the fetched word and the loaded word are valid. It sits between the IF stage and the EX/MEM outputs on one side and the SRAM pins on the other.

## Interface

**Parameters**
- `WAIT_CYCLES`, default 1: extra SRAM cycles per access. Legal range 1..14.

**Ports**

Clock and reset. One clock; reset is asynchronous and active-low.
- `CLK` in 1: clock. All state changes on the rising edge.
- `RST` in 1: asynchronous, active-low reset.

Data side (from EX/MEM):
- `memReadIn` in 2: 2'b01 requests an SRAM load. Other codes are not for this block and are ignored.
- `memWriteIn` in 2: 2'b01 requests an SRAM store. Other codes are ignored.
- `ALUResultIn` in 16: data address.
- `dataIn` in 16: store data.

Fetch side:
- `ifReq` in 1: fetch request.
- `ifAddr` in 16: PC.

Pipeline outputs:
- `memDataOut` out 16: registered load result.
- `instrOut` out 16: registered fetched word.
- `stall` out 1: hold PC and all pipeline registers.

SRAM pins:
- `ramAddr` out 16: registered address.
- `ramDataOut` out 16: registered write data.
- `ramDataIn` in 16: read data.
- `ramDataOE` out 1: drive the data bus.
- `ramCE_N`, `ramOE_N`, `ramWE_N` out 1 each: active-low strobes, all registered.

## Operation

Request decode:
- `dRd = (memReadIn == 2'b01)`.
- `dWr = (memWriteIn == 2'b01) & ~dRd`. A load wins when both are 01.

States: IDLE, D_RD, D_WR, FETCH, DONE. A 4-bit phase counter `ph` is cleared on every state entry.

- **IDLE**
  - Strobes inactive, `ramDataOE=0`.
  - Next state: D_RD if `dRd`; else D_WR if `dWr`; else FETCH if `ifReq`; else stay.
  - On exit, latch the relevant address into `ramAddr` (`ALUResultIn` or `ifAddr`). On entry to D_WR, also latch `dataIn` into `ramDataOut`.
- **D_RD**
  - `ramCE_N=0`, `ramOE_N=0`.
  - Lasts WAIT_CYCLES+1 cycles (`ph` = 0..WAIT_CYCLES).
  - At the edge ending `ph==WAIT_CYCLES`: capture `ramDataIn` into `memDataOut`.
  - Next state: FETCH if `ifReq` (latching `ifAddr` into `ramAddr`), else DONE.
- **D_WR**
  - `ramCE_N=0`, `ramDataOE=1` throughout.
  - Lasts WAIT_CYCLES+2 cycles.
  - `ramWE_N=0` only for `ph` = 1..WAIT_CYCLES. `ph=0` is address/data setup; `ph=WAIT_CYCLES+1` is hold with `ramWE_N=1`.
  - Exit is the same as D_RD.
- **FETCH**
  - Same strobe pattern and length as D_RD.
  - At the final edge: capture `ramDataIn` into `instrOut`. Next state DONE.
- **DONE**
  - Strobes inactive.
  - `stall=0`, so the pipeline advances at the end of this cycle.
  - Inputs are ignored, because they still show the retiring request.
  - Next state IDLE, unconditionally.

`stall` is combinational:
- IDLE: `dRd | dWr | ifReq`.
- D_RD, D_WR, FETCH: 1.
- DONE: 0.
- While `RST` is low: 0.

`memDataOut` and `instrOut` hold their values until the next capture.

## Timing

**Reset** (asynchronous, takes effect immediately, including mid-access):
- State IDLE, `ph=0`.
- `ramCE_N=ramOE_N=ramWE_N=1`, `ramDataOE=0`.
- `ramAddr=0`, `ramDataOut=0`, `memDataOut=0`, `instrOut=0`, `stall=0`.
- An interrupted store is abandoned and leaves no partial WE pulse: WE goes high with reset.

**Latency** (W = WAIT_CYCLES, counted in cycles from the first IDLE cycle with a request to the DONE cycle inclusive):

| Access | Sequence | Total cycles |
|---|---|---|
| Fetch only | 1 IDLE + (W+1) + 1 DONE | W+3 |
| Load + fetch | 1 + (W+1) + (W+1) + 1 | 2W+4 |
| Store + fetch | 1 + (W+2) + (W+1) + 1 | 2W+5 |

**Signal timing rules:**
- Address and data are stable for the whole access.
- `ramWE_N` never changes on the same edge as `ramAddr`.
- `ramOE_N` and `ramWE_N` are never low together.
- Read capture happens only on the final phase edge.

**Input changes mid-access:** inputs are sampled only in IDLE and at data-phase exit. Changes during an access are ignored.

## Test plan

W=1 unless stated.

- **Reset mid-store:** assert store 0x9000/0xA5A5, then pull `RST` low during `ph=1` → same instant: `ramWE_N=1`, `ramCE_N=1`, `ramDataOE=0`, `stall=0`, all registers 0. After release, IDLE restarts the store from `ph=0`.
- **Fetch only:** `ifReq=1`, `ifAddr=0x0040`, SRAM returns 0x1234 → `stall`=1,1,1 then 0 in DONE (cycle 4). `instrOut=0x1234` in DONE. `ramAddr=0x0040` for both FETCH cycles.
- **Load + fetch:** `memReadIn=01`, `ALUResultIn=0x8000` (SRAM returns 0xBEEF), `ifAddr=0x0041` (returns 0x5678) → `ramAddr` sequence 0x8000,0x8000,0x0041,0x0041. DONE in cycle 6 with `memDataOut=0xBEEF`, `instrOut=0x5678`.
- **Store only:** `memWriteIn=01`, addr 0x9000, data 0xA5A5, `ifReq=0` → D_WR 3 cycles with `ramDataOE=1` and `ramDataOut=0xA5A5` throughout. `ramWE_N` low only in the middle cycle. DONE in cycle 5.
- **Ignored encodings:** `memReadIn=10`, `memWriteIn=11`, `ifReq=1` → no data transaction, pure fetch timing (W+3). Repeat with W=3 → FETCH lasts 4 cycles.
- **Read/write conflict:** `memReadIn=01` and `memWriteIn=01` together → D_RD taken, `ramWE_N` stays 1 for the entire sequence.
